jtag_drv: RTL

- Cycle-accurate JTAG master that converts single-word commands into TCK/TMS/TDI sequences and captures TDO.
- It is the initiating end of the JTAG_TCK/TMS/TDI/TDO interface that the SoC's debug TAP responds to.
- Used on the host/bench side to bring the TAP to Run-Test/Idle and to run IR and DR scans of 1..32 bits.
- Replaces hand-written pin wiggling in benches, and serves as the seed of an on-chip debug bridge.

---
 rtl/jtag_drv.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/jtag_drv.sv
// JTAG master: turns single-word TAP-reset / IR-scan / DR-scan commands into
// TCK/TMS/TDI bit sequences and collects TDO into a response word.
module jtag_drv #(
  parameter int CLK_DIV = 2,
  parameter int RTI_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        JTAG_TCK,
  output logic        JTAG_TMS,
  output logic        JTAG_TDI,
  input  logic        JTAG_TDO
);

  localparam int HW     = $clog2(CLK_DIV) + 1;
  localparam int PH_MAX = (RTI_CYC > 6) ? RTI_CYC : 6;
  localparam int PW     = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_START, S_TRST, S_HDR, S_SHIFT, S_TAIL, S_RTI
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   half_q;
  logic [PW-1:0]   ph_q, ph_d;
  logic [5:0]      bit_q, bit_d;
  logic            pend_q;
  logic            adv, done;
  logic            run_seq, half_end, bit_end, tck_rise, accept;

  logic [31:0]     data_q;
  logic [31:0]     cap_q;
  logic [4:0]      len_q;
  logic            ir_q;
  logic            scan_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run_seq   = (state_q != S_IDLE) && (state_q != S_START);
  assign half_end  = (half_q == HW'(CLK_DIV - 1));
  assign bit_end   = run_seq && JTAG_TCK && half_end;
  assign tck_rise  = run_seq && !JTAG_TCK && half_end;

  // TMS/TDI for a given sequence position; IDLE and RTI drive both low.
  function automatic logic [1:0] pins(input state_t s, input logic [PW-1:0] ph,
                                      input logic [5:0] b);
    logic tms;
    logic tdi;
    tms = 1'b0;
    tdi = 1'b0;
    case (s)
      S_INIT, S_TRST: tms = (ph < PW'(5));
      S_HDR:          tms = ir_q ? (ph < PW'(2)) : (ph == '0);
      S_SHIFT: begin
        tms = (b == {1'b0, len_q});
        tdi = data_q[b[4:0]];
      end
      S_TAIL:         tms = (ph == '0);
      default:        tms = 1'b0;
    endcase
    return {tms, tdi};
  endfunction

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    adv     = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_START;
      S_START: begin
        adv     = 1'b1;
        ph_d    = '0;
        bit_d   = '0;
        state_d = scan_q ? S_HDR : S_TRST;
      end
      S_INIT, S_TRST: if (bit_end) begin
        adv = 1'b1;
        if (ph_q == PW'(5)) begin
          ph_d = '0;
          if (RTI_CYC > 0) state_d = S_RTI;
          else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end else ph_d = ph_q + PW'(1);
      end
      S_HDR: if (bit_end) begin
        adv = 1'b1;
        if (ph_q == (ir_q ? PW'(3) : PW'(2))) begin
          state_d = S_SHIFT;
          bit_d   = '0;
        end else ph_d = ph_q + PW'(1);
      end
      S_SHIFT: if (bit_end) begin
        adv = 1'b1;
        if (bit_q == {1'b0, len_q}) begin
          state_d = S_TAIL;
          ph_d    = '0;
        end else bit_d = bit_q + 6'd1;
      end
      S_TAIL: if (bit_end) begin
        adv = 1'b1;
        if (ph_q == PW'(1)) begin
          ph_d = '0;
          if (RTI_CYC > 0) state_d = S_RTI;
          else begin
            state_d = S_IDLE;
            done    = 1'b1;
          end
        end else ph_d = ph_q + PW'(1);
      end
      S_RTI: if (bit_end) begin
        adv = 1'b1;
        if (ph_q == PW'(RTI_CYC - 1)) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else ph_d = ph_q + PW'(1);
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control: state, TCK divider, pins and response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      half_q    <= '0;
      ph_q      <= '0;
      bit_q     <= '0;
      pend_q    <= 1'b0;
      JTAG_TCK  <= 1'b0;
      JTAG_TMS  <= 1'b1;
      JTAG_TDI  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      rsp_valid <= done && pend_q;
      if (done && pend_q) rsp_data <= cap_q;
      if (accept) pend_q <= 1'b1;
      else if (done) pend_q <= 1'b0;
      if (run_seq) begin
        if (half_end) begin
          half_q   <= '0;
          JTAG_TCK <= ~JTAG_TCK;
        end else half_q <= half_q + HW'(1);
      end else half_q <= '0;
      if (adv) {JTAG_TMS, JTAG_TDI} <= pins(state_d, ph_d, bit_d);
    end
  end

  // Command latch and TDO capture; every accept reloads them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= cmd_data;
      len_q  <= cmd_len;
      ir_q   <= (cmd_type == 2'b01);
      scan_q <= (cmd_type == 2'b01) || (cmd_type == 2'b10);
      cap_q  <= '0;
    end else if (tck_rise && state_q == S_SHIFT) begin
      cap_q[bit_q[4:0]] <= JTAG_TDO;
    end
  end

endmodule
